// File: rtl/idc_pkg.sv
// Shared definitions for the ID checker front end.
//   ID_LEN          number of characters / symbols in one national ID
//   parser_state_e  character parser state encoding
//   CH_*            ASCII codes used by the format checks
//   id_sym_t        one numeric symbol handed to the ID checker
package idc_pkg;

    localparam int ID_LEN = 10;

    typedef logic [5:0] id_sym_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT,
        GAP
    } parser_state_e;

    localparam logic [7:0] CH_A = 8'h41;
    localparam logic [7:0] CH_Z = 8'h5A;
    localparam logic [7:0] CH_0 = 8'h30;
    localparam logic [7:0] CH_9 = 8'h39;
    localparam logic [7:0] CH_1 = 8'h31;
    localparam logic [7:0] CH_2 = 8'h32;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/id_letter_lut.sv
// Maps an ASCII uppercase letter to its national-ID area code (10..35).
//   ascii      input  8  character to translate
//   code       output 6  area code, 0 when not a letter
//   letter_ok  output 1  ascii is 'A'..'Z'
module id_letter_lut
    import idc_pkg::*;
(
    input  logic [7:0] ascii,
    output id_sym_t    code,
    output logic       letter_ok
);

    // The code assignment is not alphabetical: I, O, W, X, Y, Z were added
    // to the scheme later and received out-of-order codes.
    always_comb begin
        code      = '0;
        letter_ok = (ascii >= CH_A) && (ascii <= CH_Z);
        case (ascii)
            "A": code = 6'd10;
            "B": code = 6'd11;
            "C": code = 6'd12;
            "D": code = 6'd13;
            "E": code = 6'd14;
            "F": code = 6'd15;
            "G": code = 6'd16;
            "H": code = 6'd17;
            "I": code = 6'd34;
            "J": code = 6'd18;
            "K": code = 6'd19;
            "L": code = 6'd20;
            "M": code = 6'd21;
            "N": code = 6'd22;
            "O": code = 6'd35;
            "P": code = 6'd23;
            "Q": code = 6'd24;
            "R": code = 6'd25;
            "S": code = 6'd26;
            "T": code = 6'd27;
            "U": code = 6'd28;
            "V": code = 6'd29;
            "W": code = 6'd32;
            "X": code = 6'd30;
            "Y": code = 6'd31;
            "Z": code = 6'd33;
            default: code = '0;
        endcase
    end

endmodule

// File: rtl/id_char_parser.sv
// Serial national-ID character parser feeding the ID checker.
// Checks the frame format, buffers a whole ID and replays it as one
// contiguous 10-cycle symbol burst, followed by a quiet gap.
//   clk        input  1  clock, rising edge
//   rst_n      input  1  asynchronous active-low reset
//   in_valid   input  1  in_char/in_sof valid
//   in_char    input  8  ASCII character
//   in_sof     input  1  first character of a frame
//   in_ready   output 1  character accepted when in_valid && in_ready
//   out_valid  output 1  symbol burst valid
//   out_id     output 6  letter code or digit, 0 outside a burst
//   fmt_err    output 1  one-cycle pulse per rejected frame
//
// state   | meaning
// IDLE    | waiting for a start-of-frame character
// COLLECT | storing characters 1..9 of a frame
// EMIT    | replaying the 10 buffered symbols
// GAP     | quiet time so the checker can finish and re-arm
module id_char_parser
    import idc_pkg::*;
#(
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    input  logic       in_sof,
    output logic       in_ready,
    output logic       out_valid,
    output id_sym_t    out_id,
    output logic       fmt_err
);

    localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [3:0] LAST_IDX = 4'(ID_LEN - 1);

    parser_state_e state_q, state_nxt;
    logic [3:0]    cnt_q, cnt_nxt;
    logic [GAP_W-1:0] gap_q, gap_nxt;
    id_sym_t       sym_q [ID_LEN];

    logic          sym_we;
    logic [3:0]    sym_idx;
    id_sym_t       sym_val;
    logic          err_nxt;
    logic          in_ready_nxt, out_valid_nxt;
    id_sym_t       out_id_nxt;

    id_sym_t       lut_code;
    logic          letter_ok;
    logic          xfer;
    logic          pos_ok;
    id_sym_t       digit_val;

    id_letter_lut u_letter_lut (
        .ascii     (in_char),
        .code      (lut_code),
        .letter_ok (letter_ok)
    );

    assign xfer      = in_valid && in_ready;
    assign digit_val = id_sym_t'(in_char - CH_0);
    assign pos_ok    = (cnt_q == 4'd1) ? ((in_char == CH_1) || (in_char == CH_2))
                                       : is_digit(in_char);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_id    <= '0;
            fmt_err   <= 1'b0;
            for (int i = 0; i < ID_LEN; i++) sym_q[i] <= '0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            gap_q     <= gap_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_id    <= out_id_nxt;
            fmt_err   <= err_nxt;
            if (sym_we) sym_q[sym_idx] <= sym_val;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        gap_nxt   = gap_q;
        err_nxt   = 1'b0;
        sym_we    = 1'b0;
        sym_idx   = cnt_q;
        sym_val   = digit_val;
        case (state_q)
            IDLE: begin
                if (xfer && in_sof) begin
                    if (letter_ok) begin
                        state_nxt = COLLECT;
                        cnt_nxt   = 4'd1;
                        sym_we    = 1'b1;
                        sym_idx   = '0;
                        sym_val   = lut_code;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (xfer) begin
                    if (in_sof) begin
                        // Restart: the abandoned frame is reported, and the
                        // new character is judged as a fresh character 0.
                        err_nxt = 1'b1;
                        if (letter_ok) begin
                            cnt_nxt = 4'd1;
                            sym_we  = 1'b1;
                            sym_idx = '0;
                            sym_val = lut_code;
                        end else begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end else if (!pos_ok) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        sym_we = 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            state_nxt = EMIT;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_q + 4'd1;
                        end
                    end
                end
            end
            EMIT: begin
                if (cnt_q == LAST_IDX) begin
                    cnt_nxt = '0;
                    if (GAP_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = GAP;
                        gap_nxt   = GAP_W'(GAP_LOAD);
                    end
                end else begin
                    cnt_nxt = cnt_q + 4'd1;
                end
            end
            GAP: begin
                if (gap_q == '0) state_nxt = IDLE;
                else             gap_nxt   = gap_q - GAP_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they can be registered
    // without adding a cycle of latency; during EMIT cnt_nxt is the index
    // of the symbol shown in the coming cycle.
    always_comb begin
        in_ready_nxt  = (state_nxt == IDLE) || (state_nxt == COLLECT);
        out_valid_nxt = (state_nxt == EMIT);
        out_id_nxt    = out_valid_nxt ? sym_q[cnt_nxt] : '0;
    end

endmodule
